// File: rtl/reg_coh_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | reg_coh_pkg: shared types and helpers for reg_coherence_tracker  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package reg_coh_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    UPD  = 2'd2
  } renew_state_e;

  localparam int unsigned c_slot_bus_max = 256;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned slot_extract(
    input logic [c_slot_bus_max-1:0] bus,
    input int unsigned               k,
    input int unsigned               rw
  );
    logic [c_slot_bus_max-1:0] shifted;
    shifted = bus >> (k * rw);
    return 32'(shifted) & ((32'd1 << rw) - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_coh_proc_fsm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | reg_coh_proc_fsm: per-processor renew FSM with latched slot mask  |
// | Optional watchdog under RENEW_TIMEOUT_EN.            Rev 1.0      |
// +------------------------------------------------------------------+
module reg_coh_proc_fsm
  import reg_coh_pkg::*;
#(
  parameter int unsigned REGISTER_AMOUNT = 32
`ifdef RENEW_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_grant,
  input  logic                       i_proc_idle,
  input  logic [REGISTER_AMOUNT-1:0] i_req_mask,
  output logic                       o_idle,
  output logic                       o_timeout,
  output logic [REGISTER_AMOUNT-1:0] o_busy_mask,
  output logic [REGISTER_AMOUNT-1:0] o_commit_mask
);

  renew_state_e               r_state;
  renew_state_e               w_state_nxt;
  logic [REGISTER_AMOUNT-1:0] r_mask;
  logic                       w_commit;
  logic                       w_expire;

`ifdef RENEW_TIMEOUT_EN
  localparam int unsigned TW = idx_width(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_tcnt <= '0;
    else if (r_state == IDLE)  r_tcnt <= '0;
    else                       r_tcnt <= r_tcnt + TW'(1);
  end

  // A commit on the expiry cycle wins over the abort.
  assign w_expire = (r_state != IDLE) && (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) && !w_commit;
`else
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_grant) w_state_nxt = PRE;
      PRE:     if (w_expire) w_state_nxt = IDLE;
               else if (!i_proc_idle) w_state_nxt = UPD;
      UPD:     if (i_proc_idle || w_expire) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_idle        = (r_state == IDLE);
    o_busy_mask   = (r_state == IDLE) ? '0 : r_mask;
    w_commit      = (r_state == UPD) && i_proc_idle;
    o_commit_mask = w_commit ? r_mask : '0;
    o_timeout     = w_expire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           r_mask <= '0;
    else if ((r_state == IDLE) && i_grant) r_mask <= i_req_mask;
  end

endmodule
`default_nettype wire

// File: rtl/reg_coherence_tracker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | reg_coherence_tracker: newest-owner tracking for N processors,   |
// | hazard-stalled renew arbitration, sync pulses. Optional watchdog |
// | with RENEW_TIMEOUT_EN.                               Rev 1.0     |
// +------------------------------------------------------------------+
module reg_coherence_tracker
  import reg_coh_pkg::*;
#(
  parameter int unsigned NUM_PROC        = 2,
  parameter int unsigned REGISTER_AMOUNT = 32,
  parameter int unsigned REGISTER_WIDTH  = 64,
  parameter int unsigned MAX_RENEW       = 3,
  parameter int unsigned RA_INDEX        = 1,
  parameter int unsigned TIMEOUT_CYCLES  = 1024,
  localparam int unsigned RW = idx_width(REGISTER_AMOUNT),
  localparam int unsigned PW = idx_width(NUM_PROC),
  localparam int unsigned CW = idx_width(MAX_RENEW + 1)
) (
  input  logic                                                    clk,
  input  logic                                                    rst_n,
  input  logic [NUM_PROC-1:0][REGISTER_AMOUNT-1:0][REGISTER_WIDTH-1:0] i_proc_registers,
  input  logic [NUM_PROC-1:0]                                     i_proc_idle,
  input  logic [NUM_PROC-1:0]                                     i_boot_renew,
  input  logic [MAX_RENEW*RW-1:0]                                 i_register_num,
  input  logic [CW-1:0]                                           i_renew_cnt,
  input  logic [REGISTER_WIDTH-1:0]                               i_ra_register,
  output logic [NUM_PROC-1:0]                                     o_boot_ack,
  output logic [REGISTER_AMOUNT-1:0][PW-1:0]                      o_owner_table,
  output logic [REGISTER_AMOUNT-1:0]                              o_processing_register_table,
  output logic [REGISTER_AMOUNT-1:0][REGISTER_WIDTH-1:0]          o_registers_renew,
  output logic [NUM_PROC-1:0]                                     o_synchronization,
  output logic                                                    o_synchronized_processors,
  output logic [NUM_PROC-1:0]                                     o_renew_timeout
);

  if ((NUM_PROC < 2) || (MAX_RENEW < 1) || (TIMEOUT_CYCLES < 1) ||
      (RA_INDEX >= REGISTER_AMOUNT)) begin : g_bad_cfg
    $error("reg_coherence_tracker: invalid parameter set");
  end

  logic [REGISTER_AMOUNT-1:0][PW-1:0]           r_owner;
  logic [NUM_PROC-1:0]                          r_pending;
  logic [REGISTER_AMOUNT-1:0]                   w_req_mask;
  logic [REGISTER_AMOUNT-1:0]                   w_busy;
  logic [NUM_PROC-1:0][REGISTER_AMOUNT-1:0]     w_busy_mask;
  logic [NUM_PROC-1:0][REGISTER_AMOUNT-1:0]     w_commit_mask;
  logic [NUM_PROC-1:0]                          w_idle;
  logic [NUM_PROC-1:0]                          w_grant;
  logic [NUM_PROC-1:0]                          w_fire;
  logic [NUM_PROC-1:0]                          w_timeout;
  logic [NUM_PROC-1:0]                          w_pend_set;
  logic                                         w_cnt_ok;
  logic                                         w_hazard;
  logic                                         w_found;
  int unsigned                                  w_slot;

  // RA and out-of-range slots never become busy; duplicates collapse.
  always_comb begin
    w_req_mask = '0;
    w_slot     = 0;
    for (int unsigned k = 0; k < MAX_RENEW; k++) begin
      w_slot = slot_extract(c_slot_bus_max'(i_register_num), k, RW);
      if ((CW'(k) < i_renew_cnt) && (w_slot < REGISTER_AMOUNT) && (w_slot != RA_INDEX))
        w_req_mask[RW'(w_slot)] = 1'b1;
    end
  end

  always_comb begin
    w_busy = '0;
    for (int p = 0; p < NUM_PROC; p++) w_busy = w_busy | w_busy_mask[p];
  end

  assign w_cnt_ok = (i_renew_cnt != '0) && (i_renew_cnt <= CW'(MAX_RENEW));
  assign w_hazard = |(w_req_mask & w_busy);

  // The first idle requester is the candidate; a hazard stalls it rather than passing to the next.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    for (int p = 0; p < NUM_PROC; p++) begin
      if (!w_found && i_boot_renew[p] && w_idle[p]) begin
        w_found    = 1'b1;
        w_grant[p] = w_cnt_ok && !w_hazard;
      end
    end
  end

  for (genvar p = 0; p < NUM_PROC; p++) begin : g_proc
    reg_coh_proc_fsm #(
      .REGISTER_AMOUNT (REGISTER_AMOUNT)
`ifdef RENEW_TIMEOUT_EN
      , .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
`endif
    ) u_fsm (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_grant       (w_grant[p]),
      .i_proc_idle   (i_proc_idle[p]),
      .i_req_mask    (w_req_mask),
      .o_idle        (w_idle[p]),
      .o_timeout     (w_timeout[p]),
      .o_busy_mask   (w_busy_mask[p]),
      .o_commit_mask (w_commit_mask[p])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= '0;
    end else begin
      for (int p = 0; p < NUM_PROC; p++)
        for (int r = 0; r < REGISTER_AMOUNT; r++)
          if (w_commit_mask[p][r]) r_owner[r] <= PW'(p);
    end
  end

  assign w_pend_set = (|w_grant) ? ~w_grant : '0;

  always_comb begin
    w_fire = '0;
    for (int q = 0; q < NUM_PROC; q++)
      w_fire[q] = r_pending[q] && (&w_idle) && i_proc_idle[q] && !(|i_boot_renew);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= (r_pending & ~w_fire) | w_pend_set;
  end

  always_comb begin
    for (int r = 0; r < REGISTER_AMOUNT; r++)
      o_registers_renew[r] = i_proc_registers[r_owner[r]][r];
    o_registers_renew[RA_INDEX] = i_ra_register;
  end

  assign o_boot_ack                  = w_grant;
  assign o_owner_table               = r_owner;
  assign o_processing_register_table = w_busy;
  assign o_synchronization           = w_fire;
  assign o_synchronized_processors   = ~|r_pending;
  assign o_renew_timeout             = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_reg_coherence_tracker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_reg_coherence_tracker: scenario bench for reg_coherence_tracker|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_reg_coherence_tracker;

  localparam int unsigned NP = 2, RA = 32, RWD = 64, MR = 3, RAI = 1, TO = 16;
  localparam int unsigned RW = 5, PW = 1, CW = 2;

  logic                             clk;
  logic                             rst_n;
  logic [NP-1:0][RA-1:0][RWD-1:0]   proc_regs;
  logic [NP-1:0]                    proc_idle, boot_renew, boot_ack, sync, timeout;
  logic [MR*RW-1:0]                 reg_num;
  logic [CW-1:0]                    cnt;
  logic [RWD-1:0]                   ra_reg;
  logic [RA-1:0][PW-1:0]            owner;
  logic [RA-1:0]                    busy;
  logic [RA-1:0][RWD-1:0]           view;
  logic                             synced;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { int idx; int own; } exp_t;
  exp_t sb[$];
  int   model_owner[RA];

  reg_coherence_tracker #(
    .NUM_PROC(NP), .REGISTER_AMOUNT(RA), .REGISTER_WIDTH(RWD),
    .MAX_RENEW(MR), .RA_INDEX(RAI), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .i_proc_registers            (proc_regs),
    .i_proc_idle                 (proc_idle),
    .i_boot_renew                (boot_renew),
    .i_register_num              (reg_num),
    .i_renew_cnt                 (cnt),
    .i_ra_register               (ra_reg),
    .o_boot_ack                  (boot_ack),
    .o_owner_table               (owner),
    .o_processing_register_table (busy),
    .o_registers_renew           (view),
    .o_synchronization           (sync),
    .o_synchronized_processors   (synced),
    .o_renew_timeout             (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [RWD-1:0] mkval(input int p, input int r);
    return 64'hC0DE_0000_0000_0000 | (64'(p) << 16) | 64'(r);
  endfunction

  function automatic logic [MR*RW-1:0] slots(input int a, input int b, input int c);
    return {5'(c), 5'(b), 5'(a)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_checks++; if (owner !== '0) begin n_fail++; $display("FAIL reset_owner: got %h want 0", owner); end
    n_checks++; if (busy !== '0) begin n_fail++; $display("FAIL reset_busy: got %h want 0", busy); end
    n_checks++; if (boot_ack !== '0) begin n_fail++; $display("FAIL reset_ack: got %b want 00", boot_ack); end
    n_checks++; if (sync !== '0) begin n_fail++; $display("FAIL reset_sync: got %b want 00", sync); end
    n_checks++; if (synced !== 1'b1) begin n_fail++; $display("FAIL reset_synced: got %b want 1", synced); end
    n_checks++; if (timeout !== '0) begin n_fail++; $display("FAIL reset_timeout: got %b want 00", timeout); end
  endtask

  task automatic test_single();
    boot_renew = 2'b10; reg_num = slots(5, 0, 0); cnt = 2'd1; #1;
    n_checks++; if (boot_ack !== 2'b10) begin n_fail++; $display("FAIL single_ack: got %b want 10", boot_ack); end
    step(); boot_renew = '0; #1;
    n_checks++; if (busy !== (32'd1 << 5)) begin n_fail++; $display("FAIL single_busy_set: got %h want %h", busy, 32'd1 << 5); end
    n_checks++; if (synced !== 1'b0) begin n_fail++; $display("FAIL single_pending: got %b want 0", synced); end
    proc_idle = 2'b01; step();
    n_checks++; if (busy[5] !== 1'b1) begin n_fail++; $display("FAIL single_busy_upd: got %b want 1", busy[5]); end
    proc_idle = 2'b11; #1;
    n_checks++; if (sync !== 2'b00) begin n_fail++; $display("FAIL single_sync_early: got %b want 00", sync); end
    step();
    n_checks++; if (owner[5] !== 1'b1) begin n_fail++; $display("FAIL single_owner: got %b want 1", owner[5]); end
    n_checks++; if (busy !== '0) begin n_fail++; $display("FAIL single_busy_clr: got %h want 0", busy); end
    n_checks++; if (sync !== 2'b01) begin n_fail++; $display("FAIL single_sync: got %b want 01", sync); end
    n_checks++; if (view[5] !== mkval(1, 5)) begin n_fail++; $display("FAIL single_view: got %h want %h", view[5], mkval(1, 5)); end
    step();
    n_checks++; if (sync !== 2'b00) begin n_fail++; $display("FAIL single_sync_once: got %b want 00", sync); end
    n_checks++; if (synced !== 1'b1) begin n_fail++; $display("FAIL single_synced: got %b want 1", synced); end
  endtask

  task automatic test_simultaneous();
    boot_renew = 2'b11; reg_num = slots(10, 0, 0); cnt = 2'd1; #1;
    n_checks++; if (boot_ack !== 2'b01) begin n_fail++; $display("FAIL simul_ack0: got %b want 01", boot_ack); end
    step(); reg_num = slots(11, 0, 0); #1;
    n_checks++; if (boot_ack !== 2'b10) begin n_fail++; $display("FAIL simul_ack1: got %b want 10", boot_ack); end
    step(); boot_renew = '0; #1;
    n_checks++; if (busy !== ((32'd1 << 10) | (32'd1 << 11))) begin n_fail++; $display("FAIL simul_busy: got %h want %h", busy, (32'd1 << 10) | (32'd1 << 11)); end
    proc_idle = 2'b00; step(); proc_idle = 2'b11; step();
    n_checks++; if ({owner[11], owner[10]} !== 2'b10) begin n_fail++; $display("FAIL simul_owner: got %b want 10", {owner[11], owner[10]}); end
    n_checks++; if (sync !== 2'b11) begin n_fail++; $display("FAIL simul_sync: got %b want 11", sync); end
    step();
  endtask

  task automatic test_hazard();
    boot_renew = 2'b10; reg_num = slots(3, 7, 9); cnt = 2'd3; #1;
    n_checks++; if (boot_ack !== 2'b10) begin n_fail++; $display("FAIL hazard_ack1: got %b want 10", boot_ack); end
    step(); boot_renew = 2'b01; reg_num = slots(7, 0, 0); cnt = 2'd1; #1;
    n_checks++; if (busy !== ((32'd1 << 3) | (32'd1 << 7) | (32'd1 << 9))) begin n_fail++; $display("FAIL hazard_busy: got %h want %h", busy, (32'd1 << 3) | (32'd1 << 7) | (32'd1 << 9)); end
    n_checks++; if (boot_ack !== 2'b00) begin n_fail++; $display("FAIL hazard_stall_pre: got %b want 00", boot_ack); end
    proc_idle = 2'b01; step();
    n_checks++; if (boot_ack !== 2'b00) begin n_fail++; $display("FAIL hazard_stall_upd: got %b want 00", boot_ack); end
    proc_idle = 2'b11; step();
    n_checks++; if (boot_ack !== 2'b01) begin n_fail++; $display("FAIL hazard_grant: got %b want 01", boot_ack); end
    n_checks++; if ({owner[9], owner[7], owner[3]} !== 3'b111) begin n_fail++; $display("FAIL hazard_owner1: got %b want 111", {owner[9], owner[7], owner[3]}); end
    step(); boot_renew = '0; proc_idle = 2'b10; step(); proc_idle = 2'b11; step();
    n_checks++; if (owner[7] !== 1'b0) begin n_fail++; $display("FAIL hazard_owner0: got %b want 0", owner[7]); end
    n_checks++; if (busy !== '0) begin n_fail++; $display("FAIL hazard_busy_clr: got %h want 0", busy); end
    step(); step();
  endtask

  task automatic test_ra_slot();
    ra_reg = 64'hDEAD_BEEF_0000_0001;
    boot_renew = 2'b10; reg_num = slots(1, 12, 0); cnt = 2'd2; #1;
    n_checks++; if (boot_ack !== 2'b10) begin n_fail++; $display("FAIL ra_ack: got %b want 10", boot_ack); end
    step(); boot_renew = '0; #1;
    n_checks++; if (busy !== (32'd1 << 12)) begin n_fail++; $display("FAIL ra_busy: got %h want %h", busy, 32'd1 << 12); end
    proc_idle = 2'b01; step(); proc_idle = 2'b11; step();
    n_checks++; if ({owner[12], owner[1]} !== 2'b10) begin n_fail++; $display("FAIL ra_owner: got %b want 10", {owner[12], owner[1]}); end
    n_checks++; if (view[1] !== 64'hDEAD_BEEF_0000_0001) begin n_fail++; $display("FAIL ra_view: got %h want DEADBEEF00000001", view[1]); end
    n_checks++; if (view[12] !== mkval(1, 12)) begin n_fail++; $display("FAIL ra_view12: got %h want %h", view[12], mkval(1, 12)); end
    ra_reg = 64'h1234_5678_9ABC_DEF0; #1;
    n_checks++; if (view[1] !== 64'h1234_5678_9ABC_DEF0) begin n_fail++; $display("FAIL ra_view_follow: got %h want 123456789ABCDEF0", view[1]); end
    step(); step();
  endtask

  task automatic test_cnt_zero();
    boot_renew = 2'b01; reg_num = slots(14, 0, 0); cnt = 2'd0; #1;
    n_checks++; if (boot_ack !== 2'b00) begin n_fail++; $display("FAIL cnt0_ack: got %b want 00", boot_ack); end
    step();
    n_checks++; if (busy !== '0) begin n_fail++; $display("FAIL cnt0_busy: got %h want 0", busy); end
    boot_renew = '0; cnt = 2'd1; step();
  endtask

  task automatic test_reset_mid();
    boot_renew = 2'b10; reg_num = slots(4, 0, 0); cnt = 2'd1; #1;
    n_checks++; if (boot_ack !== 2'b10) begin n_fail++; $display("FAIL rmid_ack: got %b want 10", boot_ack); end
    step(); boot_renew = '0; proc_idle = 2'b01; step();
    n_checks++; if (busy !== (32'd1 << 4)) begin n_fail++; $display("FAIL rmid_busy_upd: got %h want %h", busy, 32'd1 << 4); end
    rst_n = 1'b0; #1;
    n_checks++; if (owner !== '0) begin n_fail++; $display("FAIL rmid_async_owner: got %h want 0", owner); end
    step(); proc_idle = 2'b11; #2; rst_n = 1'b1; step();
    n_checks++; if (owner[4] !== 1'b0) begin n_fail++; $display("FAIL rmid_owner4: got %b want 0", owner[4]); end
    n_checks++; if (busy !== '0) begin n_fail++; $display("FAIL rmid_busy: got %h want 0", busy); end
    n_checks++; if (synced !== 1'b1) begin n_fail++; $display("FAIL rmid_synced: got %b want 1", synced); end
    for (int i = 0; i < RA; i++) model_owner[i] = 0;
  endtask

  task automatic test_back_to_back();
    int   p;
    int   r;
    exp_t e;
    logic [RA-1:0] exp_tab;
    for (int i = 0; i < 8; i++) begin
      p = int'($urandom_range(0, 1));
      r = int'($urandom_range(2, 31));
      boot_renew = NP'(1) << p; reg_num = slots(r, r, 0); cnt = 2'(1 + (i % 2)); #1;
      n_checks++; if (boot_ack !== (NP'(1) << p)) begin n_fail++; $display("FAIL b2b_ack[%0d]: got %b want %b", i, boot_ack, NP'(1) << p); end
      sb.push_back('{r, p});
      model_owner[r] = p;
      step(); boot_renew = '0; proc_idle = ~(NP'(1) << p); step(); proc_idle = 2'b11; step();
      e = sb.pop_front();
      n_checks++; if (owner[e.idx] !== PW'(e.own)) begin n_fail++; $display("FAIL b2b_owner[%0d]: reg %0d got %0d want %0d", i, e.idx, owner[e.idx], e.own); end
      n_checks++; if (view[e.idx] !== mkval(e.own, e.idx)) begin n_fail++; $display("FAIL b2b_view[%0d]: got %h want %h", i, view[e.idx], mkval(e.own, e.idx)); end
    end
    for (int i = 0; i < RA; i++) exp_tab[i] = model_owner[i][0];
    n_checks++; if (owner !== exp_tab) begin n_fail++; $display("FAIL b2b_table: got %h want %h", owner, exp_tab); end
    step(); step();
  endtask

`ifdef RENEW_TIMEOUT_EN
  task automatic test_timeout();
    int early;
    early = 0;
    boot_renew = 2'b10; reg_num = slots(20, 0, 0); cnt = 2'd1; #1;
    n_checks++; if (boot_ack !== 2'b10) begin n_fail++; $display("FAIL to_ack: got %b want 10", boot_ack); end
    step(); boot_renew = '0;
    for (int k = 1; k < TO; k++) begin
      if (timeout !== 2'b00) early++;
      step();
    end
    n_checks++; if (early != 0) begin n_fail++; $display("FAIL to_early: got %0d early pulses want 0", early); end
    n_checks++; if (timeout !== 2'b10) begin n_fail++; $display("FAIL to_pulse: got %b want 10", timeout); end
    n_checks++; if (busy !== (32'd1 << 20)) begin n_fail++; $display("FAIL to_busy_held: got %h want %h", busy, 32'd1 << 20); end
    step();
    n_checks++; if (timeout !== 2'b00) begin n_fail++; $display("FAIL to_pulse_end: got %b want 00", timeout); end
    n_checks++; if (busy !== '0) begin n_fail++; $display("FAIL to_busy_clr: got %h want 0", busy); end
    n_checks++; if (owner[20] !== PW'(model_owner[20])) begin n_fail++; $display("FAIL to_owner: got %0d want %0d", owner[20], model_owner[20]); end
    step(); step();
  endtask
`endif

  initial begin
    for (int p = 0; p < NP; p++)
      for (int r = 0; r < RA; r++)
        proc_regs[p][r] = mkval(p, r);
    for (int i = 0; i < RA; i++) model_owner[i] = 0;
    rst_n      = 1'b0;
    proc_idle  = 2'b11;
    boot_renew = '0;
    reg_num    = '0;
    cnt        = 2'd1;
    ra_reg     = 64'h0123_4567_89AB_CDEF;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1; #1;

    test_reset();
    test_single();
    test_simultaneous();
    test_hazard();
    test_ra_slot();
    test_cnt_zero();
    test_reset_mid();
    test_back_to_back();
`ifdef RENEW_TIMEOUT_EN
    test_timeout();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
